// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional parity, 1-2 stop bits.
// tx is registered (start bit visible the cycle after accept); tx_ready only in IDLE or on the final stop cycle.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_par;
   logic                 r_tx;

   state_t               w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic                 w_stop_idx_nxt;
   logic [DATA_BITS-1:0] w_data_nxt;
   logic                 w_par_nxt;
   logic                 w_tx_nxt;

   logic                 w_bit_end;
   logic                 w_last_stop;
   logic                 w_accept;
   logic                 w_par_calc;

   assign w_bit_end   = (r_cnt == CNT_LAST);
   assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_idx == STOP_LAST);
   assign w_accept    = tx_valid && tx_ready;
   assign w_par_calc  = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

   assign tx_ready = (r_state == S_IDLE) || w_last_stop;
   assign busy     = (r_state != S_IDLE);
   assign tx       = r_tx;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_stop_idx_nxt = r_stop_idx;
      w_data_nxt     = r_data;
      w_par_nxt      = r_par;
      w_tx_nxt       = 1'b1;

      if (r_state != S_IDLE) begin
         w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt    = (PARITY != 0) ? S_PARITY : S_STOP;
                  w_stop_idx_nxt = 1'b0;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt    = S_STOP;
               w_stop_idx_nxt = 1'b0;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_stop_idx == STOP_LAST) begin
                  w_state_nxt = w_accept ? S_START : S_IDLE;
               end else begin
                  w_stop_idx_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // The word and its parity are captured together so later tx_data changes cannot leak in.
      if (w_accept) begin
         w_data_nxt = tx_data;
         w_par_nxt  = w_par_calc;
         w_cnt_nxt  = '0;
      end

      case (w_state_nxt)
         S_IDLE:   w_tx_nxt = 1'b1;
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_data_nxt[w_idx_nxt];
         S_PARITY: w_tx_nxt = w_par_nxt;
         S_STOP:   w_tx_nxt = 1'b1;
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_stop_idx <= 1'b0;
         r_data     <= '0;
         r_par      <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_stop_idx <= w_stop_idx_nxt;
         r_data     <= w_data_nxt;
         r_par      <= w_par_nxt;
         r_tx       <= w_tx_nxt;
      end
   end

endmodule
